// File: rtl/pong_pkg.sv
// Shared definitions for the pong VGA path: attribute field codes,
// colour constants and the RRRGGGBB to 3/3/3 colour expansion.
package pong_pkg;

  // Attribute field selector carried on the object write port.
  typedef enum logic [2:0] {
    FLD_X     = 3'd0,
    FLD_Y     = 3'd1,
    FLD_W     = 3'd2,
    FLD_H     = 3'd3,
    FLD_COLOR = 3'd4,
    FLD_EN    = 3'd5
  } wr_field_e;

  localparam int         COLOR_W   = 8;
  localparam logic [7:0] COL_WHITE = 8'hFF;
  localparam logic [7:0] COL_RED   = 8'hE0;
  localparam logic [7:0] COL_BLACK = 8'h00;

  // RRRGGGBB -> {R[2:0], G[2:0], B[2:0]}; blue gains a zero LSB.
  function automatic logic [8:0] expand_color(input logic [COLOR_W-1:0] c);
    return {c[7:5], c[4:2], c[1:0], 1'b0};
  endfunction

endpackage

// File: rtl/object_hit.sv
// Registered rectangle test for one object against the current pixel.
// Bounds are evaluated one bit wider than the coordinates so an object
// reaching past the screen edge is clipped instead of wrapping.
module object_hit #(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [XW-1:0] obj_x,
  input  logic [YW-1:0] obj_y,
  input  logic [XW-1:0] obj_w,
  input  logic [YW-1:0] obj_h,
  input  logic [XW-1:0] counter_x,
  input  logic [YW-1:0] counter_y,
  output logic          hit
);

  logic [XW:0] x_end_s;
  logic [YW:0] y_end_s;
  logic        in_x_s;
  logic        in_y_s;
  logic        hit_r;

  // Half-open interval test in both axes; zero width or height never hits.
  always_comb begin
    x_end_s = {1'b0, obj_x} + {1'b0, obj_w};
    y_end_s = {1'b0, obj_y} + {1'b0, obj_h};
    in_x_s  = (counter_x >= obj_x) && ({1'b0, counter_x} < x_end_s);
    in_y_s  = (counter_y >= obj_y) && ({1'b0, counter_y} < y_end_s);
  end

  // Stage-1 hit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_r <= 1'b0;
    end else begin
      hit_r <= en & in_x_s & in_y_s;
    end
  end

  assign hit = hit_r;

endmodule

// File: rtl/object_compositor.sv
// N-object sprite compositor: double-buffered object table, per-object hit
// test, priority resolution to a 3/3/3 pixel, and per-frame ball overlap.
// Output is two cycles behind CounterX/CounterY/inDisplayArea.
module object_compositor
  import pong_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int IDW     = $clog2(NUM_OBJ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XW-1:0]      CounterX,
  input  logic [YW-1:0]      CounterY,
  input  logic               inDisplayArea,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDW-1:0]     wr_obj,
  input  logic [2:0]         wr_field,
  input  logic [9:0]         wr_data,
  output logic [2:0]         vgaRed,
  output logic [2:0]         vgaGreen,
  output logic [2:0]         vgaBlue,
  output logic               hit_any,
  output logic [IDW-1:0]     hit_id,
  output logic [NUM_OBJ-1:0] coll
);

  typedef struct packed {
    logic               en;
    logic [COLOR_W-1:0] color;
    logic [YW-1:0]      h;
    logic [XW-1:0]      w;
    logic [YW-1:0]      y;
    logic [XW-1:0]      x;
  } obj_t;

  obj_t               shadow_r [NUM_OBJ];
  obj_t               active_r [NUM_OBJ];
  logic               wr_fire_s;
  logic [NUM_OBJ-1:0] hit_s;
  logic               de_d1_r;
  logic               any_s;
  logic [IDW-1:0]     id_s;
  logic [COLOR_W-1:0] color_s;
  logic [8:0]         rgb_s;
  logic [NUM_OBJ-1:1] acc_r;
  logic [NUM_OBJ-1:0] coll_r;
  logic [2:0]         red_r;
  logic [2:0]         green_r;
  logic [2:0]         blue_r;
  logic               hit_any_r;
  logic [IDW-1:0]     hit_id_r;

  // Writes stall during reset and on the commit cycle.
  assign wr_ready  = ~reset & ~frame_start;
  assign wr_fire_s = wr_valid & wr_ready;

  // Shadow table written by the port; copied wholesale to the active table on frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_r[i] <= '0;
        active_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (frame_start) begin
          active_r[i] <= shadow_r[i];
        end
        if (wr_fire_s && (wr_obj == IDW'(i))) begin
          case (wr_field)
            FLD_X:     shadow_r[i].x     <= XW'(wr_data);
            FLD_Y:     shadow_r[i].y     <= YW'(wr_data);
            FLD_W:     shadow_r[i].w     <= XW'(wr_data);
            FLD_H:     shadow_r[i].h     <= YW'(wr_data);
            FLD_COLOR: shadow_r[i].color <= wr_data[COLOR_W-1:0];
            FLD_EN:    shadow_r[i].en    <= wr_data[0];
            default:   shadow_r[i]       <= shadow_r[i];
          endcase
        end
      end
    end
  end

  // One registered bounds compare per object against the active table.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
    object_hit #(
      .XW (XW),
      .YW (YW)
    ) u_object_hit (
      .clk       (clk),
      .reset     (reset),
      .en        (active_r[g].en),
      .obj_x     (active_r[g].x),
      .obj_y     (active_r[g].y),
      .obj_w     (active_r[g].w),
      .obj_h     (active_r[g].h),
      .counter_x (CounterX),
      .counter_y (CounterY),
      .hit       (hit_s[g])
    );
  end

  // Delay the visible flag alongside the stage-1 hit vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_d1_r <= 1'b0;
    end else begin
      de_d1_r <= inDisplayArea;
    end
  end

  // Priority resolve: scanning from the top index down leaves the lowest hit.
  always_comb begin
    id_s    = '0;
    color_s = COL_BLACK;
    any_s   = |hit_s;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      id_s    = hit_s[i] ? IDW'(i) : id_s;
      color_s = hit_s[i] ? active_r[i].color : color_s;
    end
    rgb_s = expand_color(color_s);
  end

  // Stage-2 output register; blank outside the display area or with no hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      red_r     <= 3'd0;
      green_r   <= 3'd0;
      blue_r    <= 3'd0;
      hit_any_r <= 1'b0;
      hit_id_r  <= '0;
    end else if (de_d1_r && any_s) begin
      red_r     <= rgb_s[8:6];
      green_r   <= rgb_s[5:3];
      blue_r    <= rgb_s[2:0];
      hit_any_r <= 1'b1;
      hit_id_r  <= id_s;
    end else begin
      red_r     <= 3'd0;
      green_r   <= 3'd0;
      blue_r    <= 3'd0;
      hit_any_r <= 1'b0;
      hit_id_r  <= '0;
    end
  end

  // Ball overlap accumulator; published and cleared on frame_start (blanking input ignored).
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r  <= '0;
      coll_r <= '0;
    end else if (frame_start) begin
      coll_r <= {acc_r, 1'b0};
      acc_r  <= '0;
    end else begin
      acc_r  <= acc_r | ({(NUM_OBJ-1){hit_s[0] & de_d1_r}} & hit_s[NUM_OBJ-1:1]);
    end
  end

  assign vgaRed   = red_r;
  assign vgaGreen = green_r;
  assign vgaBlue  = blue_r;
  assign hit_any  = hit_any_r;
  assign hit_id   = hit_id_r;
  assign coll     = coll_r;

endmodule

// File: tb/tb_object_compositor.sv
// Directed bench for object_compositor. A second, 3-object instance shares
// every input so writes to an object index past its table can be observed.
module tb_object_compositor;

  logic       clk;
  logic       reset;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic       inDisplayArea;
  logic       frame_start;
  logic       wr_valid;
  logic [1:0] wr_obj;
  logic [2:0] wr_field;
  logic [9:0] wr_data;

  logic       wr_ready;
  logic [2:0] vgaRed, vgaGreen, vgaBlue;
  logic       hit_any;
  logic [1:0] hit_id;
  logic [3:0] coll;

  logic       b_wr_ready;
  logic [2:0] b_red, b_green, b_blue;
  logic       b_hit_any;
  logic [1:0] b_hit_id;
  logic [2:0] b_coll;

  logic [11:0] obs;
  logic [11:0] b_obs;
  assign obs   = {vgaRed, vgaGreen, vgaBlue, hit_any, hit_id};
  assign b_obs = {b_red, b_green, b_blue, b_hit_any, b_hit_id};

  int checks = 0;
  int errors = 0;

  object_compositor #(.NUM_OBJ(4)) dut (
    .clk(clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_obj(wr_obj),
    .wr_field(wr_field), .wr_data(wr_data),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .hit_any(hit_any), .hit_id(hit_id), .coll(coll)
  );

  object_compositor #(.NUM_OBJ(3)) dut_b (
    .clk(clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_obj(wr_obj),
    .wr_field(wr_field), .wr_data(wr_data),
    .vgaRed(b_red), .vgaGreen(b_green), .vgaBlue(b_blue),
    .hit_any(b_hit_any), .hit_id(b_hit_id), .coll(b_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [1:0] o, input logic [2:0] f, input logic [9:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_obj = o; wr_field = f; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wr_all(input logic [1:0] o, input logic [9:0] x, input logic [9:0] y,
                        input logic [9:0] w, input logic [9:0] h, input logic [7:0] c,
                        input logic en);
    wr(o, 3'd0, x); wr(o, 3'd1, y); wr(o, 3'd2, w); wr(o, 3'd3, h);
    wr(o, 3'd4, {2'b00, c}); wr(o, 3'd5, {9'd0, en});
  endtask

  task automatic commit;
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Present one pixel, wait the two pipeline stages, leave outputs settled.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic de);
    @(negedge clk);
    CounterX = x; CounterY = y; inDisplayArea = de;
    @(posedge clk);
    @(posedge clk); #1;
    inDisplayArea = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      CounterX = 10'($urandom); CounterY = 10'($urandom);
      inDisplayArea = 1'($urandom); frame_start = 1'($urandom);
      wr_valid = 1'($urandom); wr_obj = 2'($urandom);
      wr_field = 3'($urandom); wr_data = 10'($urandom);
      #1;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready_low: got %b expected 0", wr_ready); end
    end
    @(negedge clk);
    reset = 1'b0; inDisplayArea = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
    CounterX = 10'd0; CounterY = 10'd0; wr_obj = 2'd0; wr_field = 3'd0; wr_data = 10'd0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL reset_pixel: got %h expected 000", obs); end
    checks++; if (coll !== 4'b0000) begin errors++; $display("FAIL reset_coll: got %b expected 0000", coll); end
    checks++; if (b_obs !== 12'h000) begin errors++; $display("FAIL reset_pixel_b: got %h expected 000", b_obs); end
  endtask

  task automatic test_single_object;
    wr_all(2'd1, 10'd100, 10'd100, 10'd300, 10'd100, 8'hE0, 1'b1);
    commit();
    pix(10'd100, 10'd100, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd1}) begin errors++; $display("FAIL single_inside: got %h expected e05", obs); end
    pix(10'd99, 10'd100, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL single_left_edge: got %h expected 000", obs); end
    pix(10'd400, 10'd100, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL single_right_edge: got %h expected 000", obs); end
    pix(10'd399, 10'd199, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd1}) begin errors++; $display("FAIL single_corner: got %h expected e05", obs); end
    pix(10'd100, 10'd100, 1'b0);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL single_not_visible: got %h expected 000", obs); end
  endtask

  task automatic test_priority;
    wr_all(2'd0, 10'd40, 10'd40, 10'd20, 10'd20, 8'hFF, 1'b1);
    wr_all(2'd2, 10'd45, 10'd45, 10'd20, 10'd20, 8'h1C, 1'b1);
    commit();
    pix(10'd50, 10'd50, 1'b1);
    checks++; if (obs !== {3'd7, 3'd7, 3'd6, 1'b1, 2'd0}) begin errors++; $display("FAIL prio_ball_wins: got %h expected %h", obs, {3'd7, 3'd7, 3'd6, 1'b1, 2'd0}); end
    wr(2'd0, 3'd5, 10'd0);
    pix(10'd50, 10'd50, 1'b1);
    checks++; if (obs !== {3'd7, 3'd7, 3'd6, 1'b1, 2'd0}) begin errors++; $display("FAIL prio_before_commit: got %h expected %h", obs, {3'd7, 3'd7, 3'd6, 1'b1, 2'd0}); end
    commit();
    checks++; if (coll !== 4'b0100) begin errors++; $display("FAIL prio_coll_obj2: got %b expected 0100", coll); end
    pix(10'd50, 10'd50, 1'b1);
    checks++; if (obs !== {3'd0, 3'd7, 3'd0, 1'b1, 2'd2}) begin errors++; $display("FAIL prio_after_disable: got %h expected %h", obs, {3'd0, 3'd7, 3'd0, 1'b1, 2'd2}); end
  endtask

  task automatic test_double_buffer;
    wr(2'd1, 3'd0, 10'd200);
    pix(10'd150, 10'd150, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd1}) begin errors++; $display("FAIL dbuf_mid_frame: got %h expected e05", obs); end
    commit();
    checks++; if (coll !== 4'b0000) begin errors++; $display("FAIL dbuf_coll_clear: got %b expected 0000", coll); end
    pix(10'd150, 10'd150, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL dbuf_old_x_gone: got %h expected 000", obs); end
    pix(10'd200, 10'd150, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd1}) begin errors++; $display("FAIL dbuf_new_x: got %h expected e05", obs); end
    // Write held across frame_start: stalled on the commit, accepted next cycle.
    @(negedge clk);
    frame_start = 1'b1; wr_valid = 1'b1; wr_obj = 2'd1; wr_field = 3'd0; wr_data = 10'd100;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL dbuf_stall_ready: got %b expected 0", wr_ready); end
    @(posedge clk); #1;
    frame_start = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL dbuf_accept_ready: got %b expected 1", wr_ready); end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    pix(10'd150, 10'd150, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL dbuf_stalled_not_committed: got %h expected 000", obs); end
    commit();
    pix(10'd150, 10'd150, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd1}) begin errors++; $display("FAIL dbuf_stalled_committed: got %h expected e05", obs); end
  endtask

  task automatic test_collision;
    wr_all(2'd0, 10'd0, 10'd0, 10'd10, 10'd10, 8'hFF, 1'b1);
    wr_all(2'd3, 10'd5, 10'd5, 10'd10, 10'd10, 8'h03, 1'b1);
    commit();
    checks++; if (coll !== 4'b0000) begin errors++; $display("FAIL coll_initial: got %b expected 0000", coll); end
    pix(10'd7, 10'd7, 1'b1);
    checks++; if (obs !== {3'd7, 3'd7, 3'd6, 1'b1, 2'd0}) begin errors++; $display("FAIL coll_pixel_ball: got %h expected %h", obs, {3'd7, 3'd7, 3'd6, 1'b1, 2'd0}); end
    commit();
    checks++; if (coll !== 4'b1000) begin errors++; $display("FAIL coll_ball_obj3: got %b expected 1000", coll); end
    wr(2'd0, 3'd0, 10'd500);
    commit();
    checks++; if (coll !== 4'b0000) begin errors++; $display("FAIL coll_next_frame: got %b expected 0000", coll); end
    pix(10'd7, 10'd7, 1'b1);
    checks++; if (obs !== {3'd0, 3'd0, 3'd6, 1'b1, 2'd3}) begin errors++; $display("FAIL coll_pixel_obj3: got %h expected %h", obs, {3'd0, 3'd0, 3'd6, 1'b1, 2'd3}); end
    commit();
    checks++; if (coll !== 4'b0000) begin errors++; $display("FAIL coll_ball_moved: got %b expected 0000", coll); end
  endtask

  task automatic test_edge_cases;
    wr(2'd2, 3'd0, 10'd1020);
    wr(2'd2, 3'd1, 10'd300);
    wr(2'd2, 3'd2, 10'd10);
    wr(2'd2, 3'd3, 10'd10);
    wr(2'd1, 3'd2, 10'd0);
    commit();
    pix(10'd1020, 10'd305, 1'b1);
    checks++; if (obs !== {3'd0, 3'd7, 3'd0, 1'b1, 2'd2}) begin errors++; $display("FAIL edge_x1020: got %h expected %h", obs, {3'd0, 3'd7, 3'd0, 1'b1, 2'd2}); end
    pix(10'd1023, 10'd305, 1'b1);
    checks++; if (obs !== {3'd0, 3'd7, 3'd0, 1'b1, 2'd2}) begin errors++; $display("FAIL edge_x1023: got %h expected %h", obs, {3'd0, 3'd7, 3'd0, 1'b1, 2'd2}); end
    pix(10'd0, 10'd305, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL edge_no_wrap: got %h expected 000", obs); end
    pix(10'd100, 10'd150, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL edge_w0_left: got %h expected 000", obs); end
    pix(10'd150, 10'd150, 1'b1);
    checks++; if (obs !== 12'h000) begin errors++; $display("FAIL edge_w0_mid: got %h expected 000", obs); end
    wr_all(2'd3, 10'd600, 10'd600, 10'd5, 10'd5, 8'hE0, 1'b1);
    commit();
    pix(10'd602, 10'd602, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd3}) begin errors++; $display("FAIL edge_obj3_written: got %h expected %h", obs, {3'd7, 3'd0, 3'd0, 1'b1, 2'd3}); end
    checks++; if (b_obs !== 12'h000) begin errors++; $display("FAIL edge_out_of_range_dropped: got %h expected 000", b_obs); end
    wr(2'd3, 3'd6, 10'd0);
    wr(2'd3, 3'd7, 10'd0);
    commit();
    pix(10'd602, 10'd602, 1'b1);
    checks++; if (obs !== {3'd7, 3'd0, 3'd0, 1'b1, 2'd3}) begin errors++; $display("FAIL edge_reserved_field: got %h expected %h", obs, {3'd7, 3'd0, 3'd0, 1'b1, 2'd3}); end
  endtask

  initial begin
    reset = 1'b1; CounterX = 10'd0; CounterY = 10'd0; inDisplayArea = 1'b0;
    frame_start = 1'b0; wr_valid = 1'b0; wr_obj = 2'd0; wr_field = 3'd0; wr_data = 10'd0;
    test_reset();
    test_single_object();
    test_priority();
    test_double_buffer();
    test_collision();
    test_edge_cases();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_compositor.md
# object_compositor

Parametrised N-object sprite compositor for the pong VGA path. It holds a double-buffered table of rectangular objects (position, size, colour, enable) and tests every object against the current `CounterX`/`CounterY` in a 2-stage pipeline. It drives the priority-resolved 3/3/3 RGB pixel and reports per-frame overlap between object 0 (the ball) and every other object. It sits between `hvsync_generator` and the VGA pins, replacing hard-wired per-object hit logic in the top level; game logic writes object attributes through a valid/ready port.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of objects, 2..16; object 0 is the ball, and a lower index has higher priority.
- `XW`, 10: width of the X coordinate and of W.
- `YW`, 10: width of the Y coordinate and of H.
- `IDW`, $clog2(NUM_OBJ): width of an object index.

Ports:
- `clk` in 1: pixel clock, the same as `hvsync_generator` (DIV_CLK[1]).
- `reset` in 1: synchronous, active-high.
- `CounterX` in XW: current pixel X.
- `CounterY` in YW: current pixel Y.
- `inDisplayArea` in 1: pixel is visible.
- `frame_start` in 1: one-cycle pulse, asserted during vertical blanking once per frame.
- `wr_valid` in 1: attribute write request.
- `wr_ready` out 1: write accepted when `wr_valid & wr_ready`.
- `wr_obj` in IDW: target object.
- `wr_field` in 3: 0=X, 1=Y, 2=W, 3=H, 4=COLOR, 5=EN; 6 and 7 are reserved.
- `wr_data` in 10: field value, LSB-aligned and truncated to the field width.
- `vgaRed` out 3: pixel red.
- `vgaGreen` out 3: pixel green.
- `vgaBlue` out 3: pixel blue.
- `hit_any` out 1: some enabled object covers the output pixel.
- `hit_id` out IDW: highest-priority object covering the output pixel; 0 when `hit_any`=0.
- `coll` out NUM_OBJ: bit i=1 if object 0 overlapped object i on a visible pixel during the previous frame; bit 0 is always 0.

## Operation
- Two tables: a shadow table, written by the port, and an active table, used for rendering.
  - Each entry holds X[XW], Y[YW], W[XW], H[YW], COLOR[8] as RRRGGGBB, and EN[1].
- Write port:
  - `wr_ready = ~reset & ~frame_start`, combinational.
  - An accepted write updates one shadow field on the next edge.
  - Writes to `wr_obj` ≥ NUM_OBJ or to a reserved field are accepted and dropped.
  - The requester holds `wr_valid` and all write fields stable until the write is accepted.
- Commit: on an edge where `frame_start`=1, the whole shadow table is copied to the active table.
  - The active table never changes mid-frame, so there is no tearing.
  - The shadow table is unchanged by a commit.
- Hit rule for object i: `EN & X ≤ CounterX < X+W & Y ≤ CounterY < Y+H`.
  - Sums are computed at XW+1 / YW+1 bits, with no wrap.
  - W=0 or H=0 never hits.
  - An object extending past 1023 is clipped, not wrapped.
- Priority: the lowest hit index wins.
- Colour expansion:
  - `vgaRed=C[7:5]`
  - `vgaGreen=C[4:2]`
  - `vgaBlue={C[1:0],1'b0}`
- Outside the display area, or with no hit: RGB=0, `hit_any`=0, `hit_id`=0.
- Collision accumulator `acc[NUM_OBJ-1:1]`:
  - Each stage-1 cycle with the delayed `inDisplayArea` high and hit[0]&hit[i] sets acc[i].
  - On `frame_start`: `coll <= {acc,1'b0}`, then acc clears. A contribution in that same cycle is discarded; it is blanking.
- Reset clears:
  - both tables (all EN=0, all fields 0);
  - the pipeline registers, `acc`, and `coll`;
  - all RGB outputs, `hit_any`, and `hit_id` to 0.
  - Reset mid-frame blanks output from the next edge onward.

## Timing
- Latency is 2 cycles from `CounterX`/`CounterY`/`inDisplayArea` to RGB, `hit_any`, and `hit_id`.
  - Stage 1 registers the hit vector and the delayed `inDisplayArea`.
  - Stage 2 registers the priority-resolved outputs.
  - Instantiating blocks delay the h/v sync by 2 to stay aligned.
- Write to visible: a write accepted in frame k is rendered from the first pixel after the next `frame_start`. The commit edge uses the shadow value as written up to and including the previous edge.
- `frame_start` and `wr_valid` together: the commit proceeds, the write is stalled (`wr_ready`=0) and is accepted on the next cycle.
- `frame_start` and `reset` together: reset wins.
- Throughput is one pixel per clock and one write per clock.

## Structure
- Shared package `pong_pkg`:
  - field codes `FLD_X` … `FLD_EN`;
  - colour constants `COL_WHITE=8'hFF`, `COL_RED=8'hE0`, `COL_BLACK=8'h00`;
  - the object-entry struct or packed-field offsets.
- Sub-module `object_hit`: one registered bounds compare per object (XW/YW parameters), instantiated NUM_OBJ times by generate.
- The top module holds the tables, the write decode, the priority encoder, the colour expansion, and the collision logic.

## Test plan
- **Reset:** reset for 3 cycles with random inputs → RGB=0, `hit_id`=0, `coll`=0, `wr_ready`=1 on the first cycle after release.
- **Single object:** write obj1 {X=100, Y=100, W=300, H=100, COLOR=E0, EN=1}, then pulse `frame_start`.
  - Pixel (100,100) → RGB=7/0/0 two cycles later.
  - Pixels (99,100) and (400,100) → black.
- **Priority:** obj0 and obj2 overlap at (50,50) → `hit_id`=0 with obj0's colour; disable obj0 → `hit_id`=2 after the next commit only.
- **Double buffer:** change obj1 X mid-frame → the rendered X is unchanged until `frame_start`; a write held during `frame_start` → `wr_ready`=0 that cycle and the write is accepted on the next.
- **Collision:** ball {X=0, Y=0, W=10, H=10} overlaps obj3 on a visible pixel → `coll`=4'b1000 after `frame_start`; move the ball away → `coll`=0 after the following frame.
- **Edge cases:**
  - X=1020, W=10 → hits at 1020..1023, no hit at CounterX=0.
  - W=0 → never hits.
  - A write to `wr_obj`=NUM_OBJ → no table change.
